// File: rtl/rv32i_dbg_apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_dbg_apb_master_if
// Brief    : Host command/response link plus APB bus for the debug master.
// Revision : 1.0
// ============================================================================
interface rv32i_dbg_apb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_poll;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic [DATA_W-1:0] cmd_match;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_dbg_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_dbg_apb_master
// Brief    : Single-command APB initiator for the RV32I debug register space.
// Revision : 1.0
// ============================================================================
module rv32i_dbg_apb_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int POLL_MAX    = 1024,
  parameter int POLL_GAP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32i_dbg_apb_master_if.master bus_io
);

  localparam int C_TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int C_PCNT_W = $clog2(POLL_MAX + 1);
  localparam int C_GAP_W  = $clog2(POLL_GAP + 1);

  localparam logic [C_TMO_W-1:0]  C_TMO_LAST = C_TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [C_PCNT_W-1:0] C_POLL_MAX = C_PCNT_W'(POLL_MAX);
  localparam logic [C_GAP_W-1:0]  C_GAP_LAST = C_GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                psel_q;
  logic                penable_q;
  logic                write_q;
  logic                poll_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mask_q;
  logic [DATA_W-1:0]   match_q;
  logic [C_TMO_W-1:0]  tmo_q;
  logic [C_PCNT_W-1:0] poll_cnt_q;
  logic [C_GAP_W-1:0]  gap_q;

  logic [C_PCNT_W-1:0] poll_cnt_d;
  logic                w_poll_hit;

  assign poll_cnt_d = poll_cnt_q + 1'b1;
  assign w_poll_hit = ((bus_io.prdata & mask_q) == match_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      write_q     <= 1'b0;
      poll_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      match_q     <= '0;
      tmo_q       <= '0;
      poll_cnt_q  <= '0;
      gap_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            write_q     <= bus_io.cmd_write;
            poll_q      <= bus_io.cmd_poll & ~bus_io.cmd_write;
            addr_q      <= bus_io.cmd_addr;
            wdata_q     <= bus_io.cmd_wdata;
            mask_q      <= bus_io.cmd_mask;
            match_q     <= bus_io.cmd_match;
            poll_cnt_q  <= '0;
            psel_q      <= 1'b1;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          tmo_q     <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus_io.pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= write_q ? '0 : bus_io.prdata;
            if (poll_q) begin
              poll_cnt_q <= poll_cnt_d;
              if (bus_io.pslverr || w_poll_hit || (poll_cnt_d == C_POLL_MAX)) begin
                // Error only if the loop ended without a clean match
                err_q       <= bus_io.pslverr | ~w_poll_hit;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end else begin
                gap_q   <= '0;
                state_q <= S_GAP;
              end
            end else begin
              err_q       <= bus_io.pslverr;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end else if (tmo_q == C_TMO_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == C_GAP_LAST) begin
            psel_q  <= 1'b1;
            state_q <= S_SETUP;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus_io.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.cmd_ready = cmd_ready_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;
  assign bus_io.psel      = psel_q;
  assign bus_io.penable   = penable_q;
  assign bus_io.pwrite    = write_q;
  assign bus_io.paddr     = addr_q;
  assign bus_io.pwdata    = wdata_q;

endmodule
`default_nettype wire
